// File: rtl/axi4_wr_pkg.sv
// axi4_wr_pkg: defaults and command typedef shared by the write command FIFO and write master.
// Revision: 1.0
`default_nettype none

package axi4_wr_pkg;

  localparam int CMD_DEPTH = 16;
  localparam int CMD_AW    = 32;
  localparam int CMD_DW    = 32;

  typedef struct packed {
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] data;
  } wr_cmd_t;

endpackage

`default_nettype wire

// File: rtl/axi4_wr_cmd_ram.sv
// axi4_wr_cmd_ram: DEPTH x W register array, synchronous write, asynchronous read.
// Revision: 1.0
`default_nettype none

module axi4_wr_cmd_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; level gates every read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/axi4_wr_cmd_fifo.sv
// axi4_wr_cmd_fifo: command queue feeding the single-beat AXI4 write master.
// Revision: 1.0
`default_nettype none

module axi4_wr_cmd_fifo
  import axi4_wr_pkg::*;
#(
  parameter int DEPTH = CMD_DEPTH,
  parameter int AW    = CMD_AW,
  parameter int DW    = CMD_DW
) (
  input  logic                     m_aclk,
  input  logic                     m_arst_n,
  input  logic [AW-1:0]            s_wr_addr,
  input  logic [DW-1:0]            s_wr_data,
  input  logic                     s_wr_valid,
  output logic                     s_wr_ready,
  output logic [AW-1:0]            wr_addr,
  output logic [DW-1:0]            wr_data,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [15:0]              done_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [LW-1:0] level_nxt;
  logic          push, pop;
  cmd_t          wcmd, head;

  assign s_wr_ready = !full && !flush;
  assign push       = s_wr_valid && s_wr_ready;
  assign pop        = wr_ready && !empty;
  assign wr_valid   = !empty;
  assign wcmd       = '{addr: s_wr_addr, data: s_wr_data};

  axi4_wr_cmd_ram #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_ram (
    .clk   (m_aclk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wcmd),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign wr_addr = empty ? '0 : head.addr;
  assign wr_data = empty ? '0 : head.data;

  // Flush keeps only the head (or nothing if the head pops this cycle);
  // wr_ptr lands just past the current head in both cases.
  always_comb begin
    rd_ptr_nxt = rd_ptr + PW'(pop);
    wr_ptr_nxt = wr_ptr;
    level_nxt  = level;
    if (flush && !empty) begin
      wr_ptr_nxt = rd_ptr + PW'(1);
      level_nxt  = pop ? LW'(0) : LW'(1);
    end else begin
      wr_ptr_nxt = wr_ptr + PW'(push);
      level_nxt  = level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge m_aclk or negedge m_arst_n) begin
    if (!m_arst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      done_cnt <= '0;
    end else begin
      rd_ptr   <= rd_ptr_nxt;
      wr_ptr   <= wr_ptr_nxt;
      level    <= level_nxt;
      full     <= (level_nxt == LW'(DEPTH));
      empty    <= (level_nxt == '0);
      done_cnt <= done_cnt + 16'(pop);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi4_wr_cmd_fifo.sv
// tb_axi4_wr_cmd_fifo: directed self-checking bench for the write command FIFO.
// Revision: 1.0
`default_nettype none

module tb_axi4_wr_cmd_fifo;

  logic        m_aclk = 1'b0;
  logic        m_arst_n = 1'b0;
  logic [31:0] s_wr_addr = '0;
  logic [31:0] s_wr_data = '0;
  logic        s_wr_valid = 1'b0;
  logic        s_wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  level;
  logic        full;
  logic        empty;
  logic [15:0] done_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_done = '0;

  always #5 m_aclk = ~m_aclk;

  axi4_wr_cmd_fifo #(.DEPTH(16), .AW(32), .DW(32)) dut (
    .m_aclk     (m_aclk),
    .m_arst_n   (m_arst_n),
    .s_wr_addr  (s_wr_addr),
    .s_wr_data  (s_wr_data),
    .s_wr_valid (s_wr_valid),
    .s_wr_ready (s_wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .flush      (flush),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .done_cnt   (done_cnt)
  );

  task automatic tick();
    @(posedge m_aclk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    s_wr_addr  = a;
    s_wr_data  = d;
    s_wr_valid = 1'b1;
    tick();
    s_wr_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (s_wr_ready !== 1'b1 || wr_valid !== 1'b0 || wr_addr !== 32'h0 || wr_data !== 32'h0 ||
        level !== 5'd0 || full !== 1'b0 || empty !== 1'b1 || done_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL %s: rdy=%b vld=%b addr=%h data=%h lvl=%0d full=%b empty=%b done=%0d, required 1 0 0 0 0 0 1 0",
               tag, s_wr_ready, wr_valid, wr_addr, wr_data, level, full, empty, done_cnt);
    end
  endtask

  task automatic test_reset();
    m_arst_n = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    m_arst_n = 1'b1;
    tick();
    exp_done = '0;
  endtask

  task automatic test_single();
    s_wr_addr  = 32'h1000_0000;
    s_wr_data  = 32'hDEAD_BEEF;
    s_wr_valid = 1'b1;
    tick();
    s_wr_valid = 1'b0;
    n_checks++;
    if (wr_valid !== 1'b1 || wr_addr !== 32'h1000_0000 || wr_data !== 32'hDEAD_BEEF || level !== 5'd1) begin
      n_fail++;
      $display("FAIL single_head: vld=%b addr=%h data=%h lvl=%0d, required 1 10000000 deadbeef 1",
               wr_valid, wr_addr, wr_data, level);
    end
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    exp_done++;
    n_checks++;
    if (empty !== 1'b1 || wr_valid !== 1'b0 || done_cnt !== exp_done || wr_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL single_pop: empty=%b vld=%b done=%0d addr=%h, required 1 0 %0d 0",
               empty, wr_valid, done_cnt, wr_addr, exp_done);
    end
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    n_checks++;
    if (done_cnt !== exp_done || level !== 5'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL pop_when_empty: done=%0d lvl=%0d empty=%b, required %0d 0 1",
               done_cnt, level, empty, exp_done);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) push(32'(i * 4), 32'hA000 + 32'(i));
    n_checks++;
    if (full !== 1'b1 || s_wr_ready !== 1'b0 || level !== 5'd16 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: full=%b rdy=%b lvl=%0d empty=%b, required 1 0 16 0",
               full, s_wr_ready, level, empty);
    end
    push(32'hFF, 32'hFFFF);
    n_checks++;
    if (level !== 5'd16 || wr_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL push_at_full: lvl=%0d head=%h, required 16 0", level, wr_addr);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (wr_valid !== 1'b1 || wr_addr !== 32'(i * 4) || wr_data !== 32'hA000 + 32'(i)) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: vld=%b addr=%h data=%h, required 1 %h %h",
                 i, wr_valid, wr_addr, wr_data, 32'(i * 4), 32'hA000 + 32'(i));
      end
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      exp_done++;
    end
    n_checks++;
    if (empty !== 1'b1 || done_cnt !== exp_done || full !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_done: empty=%b done=%0d full=%b, required 1 %0d 0",
               empty, done_cnt, full, exp_done);
    end
  endtask

  task automatic test_head_stability();
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) push(32'h100 + 32'(i * 4), 32'hB000 + 32'(i));
    s_wr_valid = 1'b1;
    for (int j = 0; j < 20; j++) begin
      s_wr_addr = 32'h200 + 32'(j * 4);
      s_wr_data = 32'hC000 + 32'(j);
      tick();
      if (wr_addr !== 32'h100 || wr_data !== 32'hB000 || wr_valid !== 1'b1) bad++;
    end
    s_wr_valid = 1'b0;
    n_checks++;
    if (bad != 0 || level !== 5'd16) begin
      n_fail++;
      $display("FAIL head_stable: unstable_cycles=%0d lvl=%0d, required 0 16", bad, level);
    end
    for (int i = 0; i < 16; i++) begin
      wr_ready = 1'b1;
      tick();
      exp_done++;
    end
    wr_ready = 1'b0;
    n_checks++;
    if (empty !== 1'b1 || done_cnt !== exp_done) begin
      n_fail++;
      $display("FAIL head_drain: empty=%b done=%0d, required 1 %0d", empty, done_cnt, exp_done);
    end
  endtask

  task automatic test_push_pop();
    logic [31:0] q[$];
    logic        do_push, do_pop;
    int          bad;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      push(32'h300 + 32'(i * 4), ~(32'h300 + 32'(i * 4)));
      q.push_back(32'h300 + 32'(i * 4));
    end
    s_wr_addr = 32'h3F0; s_wr_data = ~32'h3F0; s_wr_valid = 1'b1; wr_ready = 1'b1;
    tick();
    s_wr_valid = 1'b0; wr_ready = 1'b0;
    void'(q.pop_front());
    q.push_back(32'h3F0);
    exp_done++;
    n_checks++;
    if (level !== 5'd5 || wr_addr !== 32'h304) begin
      n_fail++;
      $display("FAIL push_pop_level: lvl=%0d head=%h, required 5 304", level, wr_addr);
    end
    for (int i = 0; i < 30; i++) begin
      do_push    = (i % 3) != 2;
      do_pop     = ((i % 2) == 0) || ((i % 5) == 1);
      s_wr_addr  = 32'h400 + 32'(i * 4);
      s_wr_data  = ~(32'h400 + 32'(i * 4));
      s_wr_valid = do_push;
      wr_ready   = do_pop;
      if (do_pop && q.size() > 0) begin
        if (wr_addr !== q[0] || wr_data !== ~q[0]) bad++;
        void'(q.pop_front());
        exp_done++;
      end
      if (do_push && q.size() < 16) q.push_back(32'h400 + 32'(i * 4));
      tick();
      if (level !== 5'(q.size())) bad++;
    end
    s_wr_valid = 1'b0; wr_ready = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mixed_ops: bad_cycles=%0d, required 0", bad);
    end
    while (q.size() > 0) begin
      n_checks++;
      if (wr_addr !== q[0]) begin
        n_fail++;
        $display("FAIL mixed_drain: addr=%h, required %h", wr_addr, q[0]);
      end
      void'(q.pop_front());
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      exp_done++;
    end
    n_checks++;
    if (empty !== 1'b1 || done_cnt !== exp_done) begin
      n_fail++;
      $display("FAIL mixed_done: empty=%b done=%0d, required 1 %0d", empty, done_cnt, exp_done);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++) push(32'h500 + 32'(i * 4), 32'hD000 + 32'(i));
    flush = 1'b1; s_wr_valid = 1'b1; s_wr_addr = 32'h5FC; s_wr_data = 32'h0;
    #1;
    n_checks++;
    if (s_wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: rdy=%b, required 0", s_wr_ready);
    end
    tick();
    flush = 1'b0; s_wr_valid = 1'b0;
    n_checks++;
    if (level !== 5'd1 || wr_addr !== 32'h500 || wr_data !== 32'hD000 || wr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_keep_head: lvl=%0d addr=%h data=%h vld=%b, required 1 500 d000 1",
               level, wr_addr, wr_data, wr_valid);
    end
    push(32'h600, 32'hE000);
    push(32'h604, 32'hE001);
    flush = 1'b1; wr_ready = 1'b1;
    tick();
    flush = 1'b0; wr_ready = 1'b0;
    exp_done++;
    n_checks++;
    if (empty !== 1'b1 || level !== 5'd0 || done_cnt !== exp_done) begin
      n_fail++;
      $display("FAIL flush_pop: empty=%b lvl=%0d done=%0d, required 1 0 %0d",
               empty, level, done_cnt, exp_done);
    end
    push(32'h700, 32'hF000);
    n_checks++;
    if (wr_addr !== 32'h700 || wr_data !== 32'hF000 || level !== 5'd1) begin
      n_fail++;
      $display("FAIL post_flush_push: addr=%h data=%h lvl=%0d, required 700 f000 1",
               wr_addr, wr_data, level);
    end
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    exp_done++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (empty !== 1'b1 || level !== 5'd0 || done_cnt !== exp_done || wr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty: empty=%b lvl=%0d done=%0d vld=%b, required 1 0 %0d 0",
               empty, level, done_cnt, wr_valid, exp_done);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) push(32'h800 + 32'(i * 4), 32'h9000 + 32'(i));
    n_checks++;
    if (level !== 5'd7 || done_cnt !== exp_done) begin
      n_fail++;
      $display("FAIL pre_reset: lvl=%0d done=%0d, required 7 %0d", level, done_cnt, exp_done);
    end
    #2;
    m_arst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    tick();
    m_arst_n = 1'b1;
    exp_done = '0;
    push(32'hCAFE_0000, 32'h1234_5678);
    n_checks++;
    if (wr_addr !== 32'hCAFE_0000 || wr_data !== 32'h1234_5678 || level !== 5'd1 || done_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL post_reset_push: addr=%h data=%h lvl=%0d done=%0d, required cafe0000 12345678 1 0",
               wr_addr, wr_data, level, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_head_stability();
    test_push_pop();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
